// File: rtl/frost32_mem_initiator_pkg.sv
// Shared types for the Frost32 main-memory port: CPU access kinds, MainMem port structs and initiator FSM/grant enums.
// Types only; no latency or backpressure of its own.
package PkgFrost32Cpu;
    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;
endpackage

package PkgMainMem;
    import PkgFrost32Cpu::*;

    typedef struct packed {
        logic               req_mem_access;
        logic [31:0]        addr;
        logic [31:0]        data;
        DataInoutAccessType data_inout_access_type;
    } PortIn_MainMem;

    typedef struct packed {
        logic        wait_for_mem;
        logic [31:0] data;
    } PortOut_MainMem;
endpackage

package PkgFrost32MemInitiator;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } StMemInit;

    typedef enum logic {
        McFetch = 1'b0,
        McLdSt  = 1'b1
    } MemClient;

    localparam int WIDTH__MEM_INIT_ADDR = 32;
endpackage

// File: rtl/frost32_mem_arbiter.sv
// Two-requester alternating-priority select; combinational grant, history register updated on each grant.
// Load/store preferred unless it won last time and fetch is waiting; caller gates grants with i_grant_en.
module frost32_mem_arbiter
    import PkgFrost32MemInitiator::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_if_req,
    input  logic     i_ls_req,
    input  logic     i_grant_en,
    output logic     o_grant_vld,
    output MemClient o_grant
);
    MemClient r_last;

    assign o_grant_vld = i_grant_en && (i_if_req || i_ls_req);
    assign o_grant     = (i_if_req && (!i_ls_req || r_last == McLdSt)) ? McFetch : McLdSt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= McFetch;
        end else if (o_grant_vld) begin
            r_last <= o_grant;
        end
    end
endmodule

// File: rtl/frost32_mem_initiator.sv
// CPU bus master for MainMem: arbitrates fetch vs load/store, one access in flight, 6 cycles req-to-ack, 7-cycle spacing.
// Clients hold req until a one-cycle ack; optional WAIT abort with sticky mem_err under MEM_TIMEOUT_EN.
module frost32_mem_initiator
    import PkgFrost32Cpu::*;
    import PkgMainMem::*;
    import PkgFrost32MemInitiator::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            if_req,
    input  logic [WIDTH__MEM_INIT_ADDR-1:0] if_addr,
    output logic                            if_ack,
    output logic [31:0]                     if_data,
    input  logic                            ls_req,
    input  logic                            ls_we,
    input  logic [WIDTH__MEM_INIT_ADDR-1:0] ls_addr,
    input  logic [31:0]                     ls_wdata,
    output logic                            ls_ack,
    output logic [31:0]                     ls_rdata,
    output logic                            mem_err,
    output PortIn_MainMem                   to_mem,
    input  PortOut_MainMem                  from_mem
);
    StMemInit      r_state;
    MemClient      r_client;
    PortIn_MainMem r_to_mem;
    logic          r_if_ack;
    logic          r_ls_ack;
    logic [31:0]   r_if_data;
    logic [31:0]   r_ls_rdata;

    logic          w_if_req;
    logic          w_ls_req;
    logic          w_grant_en;
    logic          w_grant_vld;
    MemClient      w_grant;
    logic          w_mem_done;
    logic          w_timeout;
    logic [31:0]   w_rsp_data;

    // The client being acked still shows its old req this cycle; keep it out of the regrant.
    assign w_if_req   = if_req && !(r_state == RESP && r_client == McFetch);
    assign w_ls_req   = ls_req && !(r_state == RESP && r_client == McLdSt);
    assign w_grant_en = (r_state == IDLE || r_state == RESP) && !from_mem.wait_for_mem;

    frost32_mem_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_if_req    (w_if_req),
        .i_ls_req    (w_ls_req),
        .i_grant_en  (w_grant_en),
        .o_grant_vld (w_grant_vld),
        .o_grant     (w_grant)
    );

    // wait_for_mem only reflects our access once MainMem has sampled the request pulse.
    assign w_mem_done = (r_state == WAIT) && !r_to_mem.req_mem_access && !from_mem.wait_for_mem;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_mem_err;

    assign w_timeout = (r_state == WAIT) && !w_mem_done && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign mem_err   = r_mem_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_to_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign mem_err          = 1'b0;
`endif

    assign w_rsp_data = w_timeout ? 32'd0 : from_mem.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_client   <= McFetch;
            r_to_mem   <= '0;
            r_if_ack   <= 1'b0;
            r_ls_ack   <= 1'b0;
            r_if_data  <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_grant_vld) begin
                        r_client <= w_grant;
                        if (w_grant == McLdSt) begin
                            r_to_mem.addr                   <= ls_addr;
                            r_to_mem.data                   <= ls_wdata;
                            r_to_mem.data_inout_access_type <= ls_we ? DiatWrite : DiatRead;
                        end else begin
                            r_to_mem.addr                   <= if_addr;
                            r_to_mem.data_inout_access_type <= DiatRead;
                        end
                        r_state <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_to_mem.req_mem_access <= 1'b1;
                    r_state                 <= WAIT;
                end
                WAIT: begin
                    // addr/data/type stay put: MainMem re-samples them mid-access.
                    r_to_mem.req_mem_access <= 1'b0;
                    if (w_mem_done || w_timeout) begin
                        if (r_client == McFetch) begin
                            r_if_data <= w_rsp_data;
                            r_if_ack  <= 1'b1;
                        end else begin
                            r_ls_rdata <= w_rsp_data;
                            r_ls_ack   <= 1'b1;
                        end
                        r_state <= RESP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign to_mem   = r_to_mem;
    assign if_ack   = r_if_ack;
    assign if_data  = r_if_data;
    assign ls_ack   = r_ls_ack;
    assign ls_rdata = r_ls_rdata;
endmodule

// File: tb/tb_frost32_mem_initiator.sv
// Directed bench for frost32_mem_initiator against a byte-addressed big-endian MainMem model with a 3-count sequencer.
// Expected acks are queued when requests are driven and popped as acks arrive.
module tb_frost32_mem_initiator;
    import PkgFrost32Cpu::*;
    import PkgMainMem::*;
    import PkgFrost32MemInitiator::*;

    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           if_req = 1'b0;
    logic [31:0]    if_addr = '0;
    logic           if_ack;
    logic [31:0]    if_data;
    logic           ls_req = 1'b0;
    logic           ls_we = 1'b0;
    logic [31:0]    ls_addr = '0;
    logic [31:0]    ls_wdata = '0;
    logic           ls_ack;
    logic [31:0]    ls_rdata;
    logic           mem_err;
    PortIn_MainMem  to_mem;
    PortOut_MainMem from_mem = '0;

    always #5 clk = ~clk;

    frost32_mem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ack   (ls_ack),
        .ls_rdata (ls_rdata),
        .mem_err  (mem_err),
        .to_mem   (to_mem),
        .from_mem (from_mem)
    );

    // MainMem model: wait_for_mem rises on the request edge, falls three edges later; addr/data re-sampled at completion.
    logic [7:0]  mem [0:255];
    logic        m_busy = 1'b0;
    logic [1:0]  m_cnt = '0;
    logic        m_stall = 1'b0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_a = '0;
    logic [31:0] pl_w = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a]         <= pl_w[31:24];
            mem[pl_a + 8'd1]  <= pl_w[23:16];
            mem[pl_a + 8'd2]  <= pl_w[15:8];
            mem[pl_a + 8'd3]  <= pl_w[7:0];
        end
        if (m_busy) begin
            if (m_cnt != 2'd0) begin
                m_cnt <= m_cnt - 2'd1;
            end else if (!m_stall) begin
                if (to_mem.data_inout_access_type == DiatWrite) begin
                    mem[to_mem.addr[7:0]]         <= to_mem.data[31:24];
                    mem[to_mem.addr[7:0] + 8'd1]  <= to_mem.data[23:16];
                    mem[to_mem.addr[7:0] + 8'd2]  <= to_mem.data[15:8];
                    mem[to_mem.addr[7:0] + 8'd3]  <= to_mem.data[7:0];
                end else begin
                    from_mem.data <= {mem[to_mem.addr[7:0]], mem[to_mem.addr[7:0] + 8'd1],
                                      mem[to_mem.addr[7:0] + 8'd2], mem[to_mem.addr[7:0] + 8'd3]};
                end
                from_mem.wait_for_mem <= 1'b0;
                m_busy                <= 1'b0;
            end
        end else if (to_mem.req_mem_access) begin
            m_busy                <= 1'b1;
            m_cnt                 <= 2'd2;
            from_mem.wait_for_mem <= 1'b1;
        end
    end

    typedef struct {
        MemClient    c;
        logic        chk;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input MemClient c, input logic k, input logic [31:0] d);
        exp_t e;
        e.c = c;
        e.chk = k;
        e.d = d;
        sb.push_back(e);
    endtask

    // lat counts falling edges from the call until the ack is seen.
    task automatic wait_ack(output logic got_if, output logic [31:0] d, output int lat, output logic ok);
        got_if = 1'b0;
        d = '0;
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (if_ack || ls_ack) begin
                got_if = if_ack;
                d = if_ack ? if_data : ls_rdata;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_ack(input string tag, output int lat);
        exp_t        e;
        logic        gi;
        logic        ok;
        logic [31:0] d;
        wait_ack(gi, d, lat, ok);
        chk({tag, "_ack_seen"}, 64'(ok), 64'd1);
        if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_client_is_if"}, 64'(gi), 64'(e.c == McFetch));
            chk({tag, "_both_acks"}, 64'(if_ack && ls_ack), 64'd0);
            if (e.chk) chk({tag, "_data"}, 64'(d), 64'(e.d));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int bad;
        int acks;

        pl_a = 8'h10;
        pl_w = 32'hDEADBEEF;
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_to_mem", 64'(to_mem), 64'd0);
        chk("rst_if_ack", 64'(if_ack), 64'd0);
        chk("rst_ls_ack", 64'(ls_ack), 64'd0);
        chk("rst_if_data", 64'(if_data), 64'd0);
        chk("rst_ls_rdata", 64'(ls_rdata), 64'd0);
        chk("rst_mem_err", 64'(mem_err), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch read
        push(McFetch, 1'b1, 32'hDEADBEEF);
        if_addr = 32'h0000_0010;
        if_req = 1'b1;
        expect_ack("fetch", lat);
        if_req = 1'b0;
        chk("fetch_latency", 64'(lat - 1), 64'd6);
        @(negedge clk);
        chk("fetch_ack_one_cycle", 64'(if_ack || ls_ack), 64'd0);
        repeat (2) @(negedge clk);

        // Store then load
        push(McLdSt, 1'b0, 32'd0);
        ls_we = 1'b1;
        ls_addr = 32'h20;
        ls_wdata = 32'h12345678;
        ls_req = 1'b1;
        expect_ack("store", lat);
        ls_req = 1'b0;
        @(negedge clk);
        chk("store_ack_one_cycle", 64'(ls_ack), 64'd0);
        chk("store_byte_0x20", 64'(mem[8'h20]), 64'h12);
        chk("store_byte_0x23", 64'(mem[8'h23]), 64'h78);
        repeat (2) @(negedge clk);
        push(McLdSt, 1'b1, 32'h12345678);
        ls_we = 1'b0;
        ls_req = 1'b1;
        expect_ack("load", lat);
        ls_req = 1'b0;
        chk("load_latency", 64'(lat - 1), 64'd6);
        repeat (2) @(negedge clk);

        // Both held: alternating grants at 7-cycle spacing
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push(McLdSt, 1'b1, 32'h12345678);
        push(McFetch, 1'b1, 32'hDEADBEEF);
        push(McLdSt, 1'b1, 32'h12345678);
        push(McFetch, 1'b1, 32'hDEADBEEF);
        ls_addr = 32'h20;
        if_addr = 32'h10;
        ls_req = 1'b1;
        if_req = 1'b1;
        expect_ack("arb0", lat);
        chk("arb0_latency", 64'(lat - 1), 64'd6);
        for (int k = 1; k < 4; k++) begin
            expect_ack($sformatf("arb%0d", k), lat);
            chk($sformatf("arb%0d_spacing", k), 64'(lat), 64'd7);
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_ack || ls_ack) acks++;
        end
        chk("arb_no_extra_ack", 64'(acks), 64'd0);

        // Load/store drops req right after grant
        push(McLdSt, 1'b1, 32'hDEADBEEF);
        ls_addr = 32'h10;
        ls_req = 1'b1;
        @(negedge clk);
        ls_req = 1'b0;
        expect_ack("drop", lat);
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ls_ack) acks++;
        end
        chk("drop_single_pulse", 64'(acks), 64'd0);

        // Reset during WAIT; new fetch must wait for MainMem to drain
        if_addr = 32'h20;
        if_req = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstwait_req_low", 64'(to_mem.req_mem_access), 64'd0);
        chk("rstwait_wait_high", 64'(from_mem.wait_for_mem), 64'd1);
        bad = 0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            if (!from_mem.wait_for_mem) break;
            if (to_mem.req_mem_access) bad++;
            if (if_ack) acks++;
            @(negedge clk);
        end
        chk("rstwait_drained", 64'(from_mem.wait_for_mem), 64'd0);
        chk("rstwait_no_req_while_busy", 64'(bad), 64'd0);
        chk("rstwait_ack_lost", 64'(acks), 64'd0);
        push(McFetch, 1'b1, 32'h12345678);
        expect_ack("rstwait_fetch", lat);
        if_req = 1'b0;
        chk("rstwait_latency", 64'(lat - 1), 64'd6);
        repeat (3) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
        // MainMem never releases: abort after ISSUE plus TO WAIT cycles
        m_stall = 1'b1;
        push(McFetch, 1'b1, 32'd0);
        if_addr = 32'h10;
        if_req = 1'b1;
        expect_ack("timeout", lat);
        if_req = 1'b0;
        chk("timeout_latency", 64'(lat - 1), 64'(TO + 1));
        chk("timeout_mem_err", 64'(mem_err), 64'd1);
        repeat (5) @(negedge clk);
        chk("timeout_mem_err_sticky", 64'(mem_err), 64'd1);
        m_stall = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("timeout_mem_err_cleared", 64'(mem_err), 64'd0);
`else
        chk("mem_err_tied_low", 64'(mem_err), 64'd0);
`endif

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
